gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
- Synthesizable counterpart to the team's gate testbenches: drives the 2-input vector set into a gate under test, samples the gate output after a settle time, and checks it against the expected truth table.
- Runs in hardware next to the gate blocks (AND/OR/XOR/NAND).
- Reports pass/fail, error count and the first failing vector.

Parameters:
- SETTLE_CYCLES, 1, clock cycles each vector is held before s_in is sampled; legal range 1..15.
- ERR_W, 3, width of err_count.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a check run; single-cycle pulse or level.
- op_sel  input  2  expected function: 00 AND, 01 OR, 10 XOR, 11 NAND.
- a_out  output  1  gate input A to the gate under test.
- b_out  output  1  gate input B to the gate under test.
- s_in  input  1  gate output S returned from the gate under test.
- busy  output  1  run in progress.
- done  output  1  run finished; results valid.
- pass  output  1  run finished with zero mismatches.
- err_count  output  ERR_W  number of mismatching vectors.
- fail_vec  output  2  {A,B} of the first mismatching vector.
- fail_valid  output  1  fail_vec holds a valid vector.

Behaviour:
- One clock, clk. Reset is synchronous and active-high. Sampled at a rising edge, reset overrides everything.
- Reset values: a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0; state=IDLE.
- States: IDLE, APPLY, DONE.
- IDLE:
  - a_out/b_out=0.
  - start=1 at an edge: capture op_sel into op_q, clear err_count/fail_valid/fail_vec/done/pass.
  - Load vec_idx=0 and settle counter=SETTLE_CYCLES; go to APPLY with busy=1.
- Vector order, vec_idx 0..3: {A,B} = 11, 00, 10, 01.
- a_out/b_out are registered and equal the current vector throughout APPLY.
- APPLY:
  - Settle counter decrements each edge.
  - At the edge where it reaches its last cycle (SETTLE_CYCLES edges after the vector first appears), sample s_in and compare with expected(op_q, vector).
  - On mismatch: err_count increments, saturating at 2^ERR_W-1.
  - On the first mismatch of the run: also load fail_vec=vector and set fail_valid=1.
  - On the same edge, advance vec_idx, reload the counter and present the next vector. There are no gap cycles between vectors.
- After the sample of vec_idx=3:
  - Go to DONE with busy=0 and done=1.
  - pass=1 iff err_count (including this sample) is 0.
  - a_out/b_out=0.
- Latency: start edge E → done visible after edge E+4*SETTLE_CYCLES.
- DONE:
  - Results are held; done stays high.
  - start=1 restarts exactly as from IDLE: done/pass cleared on the same edge, first vector presented.
- start while busy is ignored. op_sel changes while busy are ignored (op_q is used).
- Reset mid-run: the next cycle shows all reset values, and the partial result is discarded.
- Expected function: AND a&b; OR a|b; XOR a^b; NAND ~(a&b).
- s_in is assumed synchronous to clk. The block does not synchronise it.

Test Plan:
1. AND DUT (s_in=a_out&b_out), op_sel=00, SETTLE_CYCLES=1, start pulse at edge 0:
   - a_out/b_out = 11, 00, 10, 01 after edges 0–3.
   - After edge 4: done=1, pass=1, err_count=0, fail_valid=0, busy=0, a_out=b_out=0.
2. s_in tied 0, op_sel=00:
   - err_count=1, fail_vec=2'b11, fail_valid=1, pass=0, done after edge 4.
3. OR DUT wired in, op_sel=00:
   - Mismatches on 10 and 01.
   - err_count=2, fail_vec=2'b10, pass=0.
4. SETTLE_CYCLES=3, DUT = a&b delayed by 2 registers:
   - Each vector is held 3 cycles.
   - done after edge 12, pass=1, err_count=0.
5. Reset pulse at edge 2 of a SETTLE_CYCLES=1 run:
   - After edge 2: busy=0, done=0, err_count=0, a_out=b_out=0.
   - start held high during the run is ignored until IDLE.
   - A new start completes with pass=1 after 4 more edges.
6. XOR DUT, op_sel=10 → pass=1.
   - Then, from DONE, restart with s_in tied 1 and op_sel=10.
   - Required: done/pass drop on the start edge; final err_count=2, fail_vec=2'b11, pass=0.

Source files
------------

// File: rtl/gate_vector_checker.sv
// gate_vector_checker
// Drives the four 2-input vectors into an external gate and holds each one for
// SETTLE_CYCLES clocks. It samples the gate output s_in on the last held cycle
// and compares it with the truth table selected by op_sel.
// Reports pass/fail, a saturating mismatch count and the first failing vector.
// s_in must already be synchronous to clk; this block does not synchronise it.
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 1,   // legal range 1..15
    parameter int ERR_W         = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op_sel,
    output logic             a_out,
    output logic             b_out,
    input  logic             s_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_vec,
    output logic             fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    // Vector order: index 0..3 -> {A,B} = 11, 00, 10, 01
    function automatic logic [1:0] vec_of(input logic [1:0] idx);
        logic [1:0] v;
        case (idx)
            2'd0:    v = 2'b11;
            2'd1:    v = 2'b00;
            2'd2:    v = 2'b10;
            default: v = 2'b01;
        endcase
        return v;
    endfunction

    // Reference truth table: 00 AND, 01 OR, 10 XOR, 11 NAND
    function automatic logic expected_of(input logic [1:0] op, input logic [1:0] v);
        logic e;
        case (op)
            2'b00:   e = v[1] & v[0];
            2'b01:   e = v[1] | v[0];
            2'b10:   e = v[1] ^ v[0];
            default: e = ~(v[1] & v[0]);
        endcase
        return e;
    endfunction

    state_t           r_state;
    logic [1:0]       r_op;
    logic [1:0]       r_vec_idx;
    logic [3:0]       r_settle;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [1:0]       r_fail_vec;
    logic             r_fail_valid;

    logic [1:0]       w_cur_vec;
    logic [1:0]       w_next_idx;
    logic             w_last_cycle;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    // Compare logic for the vector currently on a_out/b_out
    always_comb begin
        w_cur_vec    = vec_of(r_vec_idx);
        w_next_idx   = 2'(r_vec_idx + 2'd1);
        // "<= 1" also covers an out-of-range zero setting so the run never stalls
        w_last_cycle = (r_settle <= 4'd1);
        w_mismatch   = (s_in != expected_of(r_op, w_cur_vec));
        w_err_next   = r_err;
        if (w_mismatch && (r_err != ERR_MAX)) begin
            w_err_next = ERR_MAX'(r_err + 1'b1) & ERR_MAX;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= 2'b00;
            r_vec_idx    <= 2'd0;
            r_settle     <= 4'd0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_vec   <= 2'b00;
            r_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Restart from DONE behaves exactly like a start from IDLE
                    if (start) begin
                        r_op         <= op_sel;
                        r_err        <= '0;
                        r_fail_vec   <= 2'b00;
                        r_fail_valid <= 1'b0;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_vec_idx    <= 2'd0;
                        r_settle     <= SETTLE_LD;
                        {r_a, r_b}   <= vec_of(2'd0);
                        r_busy       <= 1'b1;
                        r_state      <= S_APPLY;
                    end
                end

                S_APPLY: begin
                    if (w_last_cycle) begin
                        r_err <= w_err_next;
                        if (w_mismatch && !r_fail_valid) begin
                            r_fail_vec   <= w_cur_vec;
                            r_fail_valid <= 1'b1;
                        end
                        if (r_vec_idx == 2'd3) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_pass     <= (w_err_next == '0);
                            {r_a, r_b} <= 2'b00;
                        end else begin
                            // Next vector appears with no gap cycle
                            r_vec_idx  <= w_next_idx;
                            r_settle   <= SETTLE_LD;
                            {r_a, r_b} <= vec_of(w_next_idx);
                        end
                    end else begin
                        r_settle <= 4'(r_settle - 4'd1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_a     <= 1'b0;
                    r_b     <= 1'b0;
                end
            endcase
        end
    end

    assign a_out      = r_a;
    assign b_out      = r_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Testbench for gate_vector_checker: a table of back-to-back runs against
// behavioural gates (settle = 1), plus hand sequences for reset mid-run,
// start held high, and a slow gate with settle = 3 and a 1-bit error count.
module tb_gate_vector_checker;

    localparam int M_AND  = 0;
    localparam int M_OR   = 1;
    localparam int M_XOR  = 2;
    localparam int M_TIE0 = 3;
    localparam int M_TIE1 = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    // Instance 1: SETTLE_CYCLES = 1, ERR_W = 3
    logic       start = 1'b0;
    logic [1:0] op_sel = 2'b00;
    logic       a_out, b_out, s_in;
    logic       busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] fail_vec;
    int         mode = M_AND;

    // Instance 2: SETTLE_CYCLES = 3, ERR_W = 1, gate delayed by two registers
    logic       start2 = 1'b0;
    logic [1:0] op2 = 2'b00;
    logic       a2, b2, s2;
    logic       busy2, done2, pass2, fail_valid2;
    logic [0:0] err2;
    logic [1:0] fail_vec2;
    logic       d1 = 1'b0;
    logic       d2 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gate_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(3)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel),
        .a_out(a_out), .b_out(b_out), .s_in(s_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_vec(fail_vec), .fail_valid(fail_valid)
    );

    gate_vector_checker #(.SETTLE_CYCLES(3), .ERR_W(1)) u_dut_slow (
        .clk(clk), .reset(reset), .start(start2), .op_sel(op2),
        .a_out(a2), .b_out(b2), .s_in(s2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_vec(fail_vec2), .fail_valid(fail_valid2)
    );

    // Behavioural gate under test for instance 1
    always_comb begin
        s_in = 1'b0;
        case (mode)
            M_AND:   s_in = a_out & b_out;
            M_OR:    s_in = a_out | b_out;
            M_XOR:   s_in = a_out ^ b_out;
            M_TIE0:  s_in = 1'b0;
            default: s_in = 1'b1;
        endcase
    end

    // Slow AND gate: two register stages
    always @(posedge clk) begin
        d1 <= a2 & b2;
        d2 <= d1;
    end
    assign s2 = d2;

    typedef struct {
        int         mode;
        logic [1:0] op;
        logic [2:0] err;
        logic [1:0] fv;
        logic       fvalid;
        logic       pass;
    } run_t;

    run_t       runs[9];
    logic [1:0] vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = 2'b11; vecs[1] = 2'b00; vecs[2] = 2'b10; vecs[3] = 2'b01;
        //             mode    op     err   fv     fvalid pass
        runs[0] = '{M_AND,  2'b00, 3'd0, 2'b00, 1'b0, 1'b1};
        runs[1] = '{M_TIE0, 2'b00, 3'd1, 2'b11, 1'b1, 1'b0};
        runs[2] = '{M_OR,   2'b00, 3'd2, 2'b10, 1'b1, 1'b0};
        runs[3] = '{M_XOR,  2'b10, 3'd0, 2'b00, 1'b0, 1'b1};
        runs[4] = '{M_TIE1, 2'b10, 3'd2, 2'b11, 1'b1, 1'b0};
        runs[5] = '{M_TIE1, 2'b00, 3'd3, 2'b00, 1'b1, 1'b0};
        runs[6] = '{M_AND,  2'b11, 3'd4, 2'b11, 1'b1, 1'b0};
        runs[7] = '{M_TIE0, 2'b11, 3'd3, 2'b00, 1'b1, 1'b0};
        runs[8] = '{M_OR,   2'b01, 3'd0, 2'b00, 1'b0, 1'b1};

        // Reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_ab",    {30'd0, a_out, b_out}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_pass",  {31'd0, pass}, 32'd0);
        check("rst_err",   {29'd0, err_count}, 32'd0);
        check("rst_fv",    {30'd0, fail_vec}, 32'd0);
        check("rst_fvld",  {31'd0, fail_valid}, 32'd0);
        check("rst2_busy", {31'd0, busy2}, 32'd0);

        // Back-to-back runs; each later run restarts from DONE
        for (int r = 0; r < 9; r++) begin
            mode   = runs[r].mode;
            op_sel = runs[r].op;
            start  = 1'b1;
            tick();                         // edge 0
            start  = 1'b0;
            op_sel = ~runs[r].op;           // must be ignored while busy
            check("run_done_clr", {31'd0, done}, 32'd0);
            check("run_pass_clr", {31'd0, pass}, 32'd0);
            check("run_busy",     {31'd0, busy}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                check("run_vec", {30'd0, a_out, b_out}, {30'd0, vecs[k]});
                tick();                     // edges 1..4
            end
            check("res_done", {31'd0, done}, 32'd1);
            check("res_busy", {31'd0, busy}, 32'd0);
            check("res_pass", {31'd0, pass}, {31'd0, runs[r].pass});
            check("res_err",  {29'd0, err_count}, {29'd0, runs[r].err});
            check("res_fv",   {30'd0, fail_vec}, {30'd0, runs[r].fv});
            check("res_fvld", {31'd0, fail_valid}, {31'd0, runs[r].fvalid});
            check("res_ab",   {30'd0, a_out, b_out}, 32'd0);
            $display("[TB] run %0d mode %0d op %b -> done %b pass %b err %0d fv %b fvalid %b",
                     r, runs[r].mode, runs[r].op, done, pass, err_count, fail_vec, fail_valid);
        end

        // Reset mid-run with start held high
        mode   = M_AND;
        op_sel = 2'b00;
        start  = 1'b1;
        tick();                             // edge 0: run starts
        check("rm_start", {30'd0, a_out, b_out}, 32'd3);
        tick();                             // edge 1: held start ignored
        check("rm_ignore", {30'd0, a_out, b_out}, 32'd0);
        check("rm_busy1", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();                             // edge 2: reset
        reset = 1'b0;
        check("rm_busy", {31'd0, busy}, 32'd0);
        check("rm_done", {31'd0, done}, 32'd0);
        check("rm_err",  {29'd0, err_count}, 32'd0);
        check("rm_ab",   {30'd0, a_out, b_out}, 32'd0);
        tick();                             // edge 3: new run from IDLE
        start = 1'b0;
        check("rm_restart", {30'd0, a_out, b_out}, 32'd3);
        tick(); tick(); tick();
        check("rm_not_yet", {31'd0, done}, 32'd0);
        tick();                             // edge 7
        check("rm_done2", {31'd0, done}, 32'd1);
        check("rm_pass2", {31'd0, pass}, 32'd1);
        $display("[TB] reset-mid-run sequence: done %b pass %b", done, pass);

        // Slow gate, settle = 3: pass with AND, then NAND with saturation
        op2    = 2'b00;
        start2 = 1'b1;
        tick();                             // edge 0
        start2 = 1'b0;
        check("sl_v0_e0", {30'd0, a2, b2}, 32'd3);
        tick();
        check("sl_v0_e1", {30'd0, a2, b2}, 32'd3);
        tick();
        check("sl_v0_e2", {30'd0, a2, b2}, 32'd3);
        tick();
        check("sl_v1_e3", {30'd0, a2, b2}, 32'd0);
        for (int i = 4; i <= 11; i++) tick();
        check("sl_busy11", {31'd0, busy2}, 32'd1);
        check("sl_done11", {31'd0, done2}, 32'd0);
        tick();                             // edge 12
        check("sl_done", {31'd0, done2}, 32'd1);
        check("sl_pass", {31'd0, pass2}, 32'd1);
        check("sl_err",  {31'd0, err2}, 32'd0);
        $display("[TB] slow AND run: done %b pass %b err %0d", done2, pass2, err2);

        op2    = 2'b11;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 1; i <= 12; i++) tick();
        check("sat_done", {31'd0, done2}, 32'd1);
        check("sat_pass", {31'd0, pass2}, 32'd0);
        check("sat_err",  {31'd0, err2}, 32'd1);
        check("sat_fv",   {30'd0, fail_vec2}, 32'd3);
        check("sat_fvld", {31'd0, fail_valid2}, 32'd1);
        $display("[TB] slow NAND run: pass %b err %0d fv %b", pass2, err2, fail_vec2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
